vec_len_issuer: RTL and testbench

VEC_LEN_ISSUER -- requirements
Module: vec_len_issuer

---
 rtl/vec_len_issuer_pkg.sv | 22 ++
 rtl/vec_len_issuer_if.sv | 39 +++
 rtl/vec_len_issuer_sync.sv | 33 +++
 rtl/vec_len_issuer.sv | 163 ++++++++++++++++
 tb/tb_vec_len_issuer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vec_len_issuer_pkg.sv
// Shared types and constants for the vector-length job issuer.
// State enum, lane geometry and the quiet-NaN result used for abandoned jobs.
package vec_len_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int LANE_W  = 32;
    localparam int N_LANES = 3;
    localparam int VEC_W   = LANE_W * N_LANES;

    localparam int LANE_1 = 0;
    localparam int LANE_2 = 1;
    localparam int LANE_3 = 2;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/vec_len_issuer_if.sv
// Job, length-unit and result signals of the vector-length issuer.
// The issuer sits on the slave modport; the environment drives the master side.
interface vec_len_issuer_if #(
    parameter int TAG_W = 4
);
    import vec_len_pkg::*;

    logic              job_valid;
    logic              job_ready;
    logic [VEC_W-1:0]  job_a;
    logic [VEC_W-1:0]  job_b;
    logic [TAG_W-1:0]  job_tag;

    logic [VEC_W-1:0]  u_a;
    logic [VEC_W-1:0]  u_b;
    logic              u_rst_n;
    logic [31:0]       u_res;
    logic              u_out_rdy;

    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              res_timeout;
    logic              busy;

    modport slave (
        input  job_valid, job_a, job_b, job_tag, u_res, u_out_rdy, res_ready,
        output job_ready, u_a, u_b, u_rst_n, res_valid, res_data, res_tag,
               res_timeout, busy
    );

    modport master (
        output job_valid, job_a, job_b, job_tag, u_res, u_out_rdy, res_ready,
        input  job_ready, u_a, u_b, u_rst_n, res_valid, res_data, res_tag,
               res_timeout, busy
    );

endinterface

// File: rtl/vec_len_issuer_sync.sv
// Two-flop synchronizer for the length-unit ready level with rising-edge detect.
// An edge only counts once a synchronized low has been seen while wait_i is high.
module sync_edge_det (
    input  logic CLK2,
    input  logic RST,
    input  logic lvl_i,
    input  logic wait_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic armed_q;

    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            meta_q  <= lvl_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            // a level left high by the previous job never arms the detector
            armed_q <= wait_i & (armed_q | ~sync_q);
        end
    end

    assign rise_o = armed_q & sync_q & ~prev_q;

endmodule

// File: rtl/vec_len_issuer.sv
// Issues one vector job at a time to the length unit and returns its result.
// Optional WAIT timeout is built only when VEC_LEN_ISSUER_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | job_ready high, waiting for a job
// KICK  | u_rst_n held low for RST_CYC cycles
// WAIT  | waiting for the length unit to signal completion
// DONE  | result offered until res_ready
module vec_len_issuer
    import vec_len_pkg::*;
#(
    parameter int TAG_W       = 4,
    parameter int RST_CYC     = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input logic             CLK2,
    input logic             RST,
    vec_len_issuer_if.slave bus
);

    if (RST_CYC < 1 || RST_CYC > 15) begin : g_bad_rst_cyc
        $error("vec_len_issuer: RST_CYC must be in 1..15");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout_cyc
        $error("vec_len_issuer: TIMEOUT_CYC must be in 2..65535");
    end

    state_e            state_q, state_d;
    logic [3:0]        kick_cnt_q, kick_cnt_d;
    logic [VEC_W-1:0]  u_a_q, u_a_d;
    logic [VEC_W-1:0]  u_b_q, u_b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [31:0]       res_data_q, res_data_d;
    logic              u_rst_n_q;
    logic              job_ready_q;
    logic              done_evt;
    logic              tmo_hit;

`ifdef VEC_LEN_ISSUER_TIMEOUT_EN
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic              res_timeout_q, res_timeout_d;

    assign tmo_hit = (tmo_cnt_q == 16'd0);
`else
    assign tmo_hit = 1'b0;
`endif

    sync_edge_det u_sync (
        .CLK2   (CLK2),
        .RST    (RST),
        .lvl_i  (bus.u_out_rdy),
        .wait_i (state_q == WAIT),
        .rise_o (done_evt)
    );

    always_comb begin
        state_d    = state_q;
        kick_cnt_d = kick_cnt_q;
        u_a_d      = u_a_q;
        u_b_d      = u_b_q;
        tag_d      = tag_q;
        res_data_d = res_data_q;
`ifdef VEC_LEN_ISSUER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        res_timeout_d = res_timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.job_valid && job_ready_q) begin
                    u_a_d      = bus.job_a;
                    u_b_d      = bus.job_b;
                    tag_d      = bus.job_tag;
                    kick_cnt_d = 4'(RST_CYC - 1);
                    state_d    = KICK;
                end
            end
            KICK: begin
                if (kick_cnt_q == 4'd0) begin
                    state_d = WAIT;
`ifdef VEC_LEN_ISSUER_TIMEOUT_EN
                    tmo_cnt_d = 16'(TIMEOUT_CYC - 1);
`endif
                end else begin
                    kick_cnt_d = kick_cnt_q - 4'd1;
                end
            end
            WAIT: begin
                // completion takes priority over a same-cycle timeout
                if (done_evt) begin
                    res_data_d = bus.u_res;
                    state_d    = DONE;
`ifdef VEC_LEN_ISSUER_TIMEOUT_EN
                    res_timeout_d = 1'b0;
`endif
                end else if (tmo_hit) begin
                    res_data_d = FP_QNAN;
                    state_d    = DONE;
`ifdef VEC_LEN_ISSUER_TIMEOUT_EN
                    res_timeout_d = 1'b1;
`endif
                end else begin
`ifdef VEC_LEN_ISSUER_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q - 16'd1;
`endif
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            kick_cnt_q  <= 4'd0;
            u_a_q       <= '0;
            u_b_q       <= '0;
            tag_q       <= '0;
            res_data_q  <= 32'd0;
            u_rst_n_q   <= 1'b0;
            job_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kick_cnt_q  <= kick_cnt_d;
            u_a_q       <= u_a_d;
            u_b_q       <= u_b_d;
            tag_q       <= tag_d;
            res_data_q  <= res_data_d;
            u_rst_n_q   <= (state_d != KICK);
            job_ready_q <= (state_d == IDLE);
        end
    end

`ifdef VEC_LEN_ISSUER_TIMEOUT_EN
    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            tmo_cnt_q     <= 16'd0;
            res_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign bus.res_timeout = res_timeout_q;
`else
    assign bus.res_timeout = 1'b0;
`endif

    assign bus.job_ready = job_ready_q;
    assign bus.u_a       = u_a_q;
    assign bus.u_b       = u_b_q;
    assign bus.u_rst_n   = u_rst_n_q;
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = res_data_q;
    assign bus.res_tag   = tag_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vec_len_issuer.sv
// Self-checking bench for vec_len_issuer: directed scenarios plus random jobs
// scored against a cycle-count model of the issuer's observable behaviour.
module tb_vec_len_issuer;
    import vec_len_pkg::*;

    localparam int TAG_W       = 4;
    localparam int RST_CYC     = 2;
    localparam int TIMEOUT_CYC = 16;
`ifdef VEC_LEN_ISSUER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic CLK2 = 1'b0;
    logic RST  = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 CLK2 = ~CLK2;

    vec_len_issuer_if #(.TAG_W(TAG_W)) bus ();

    vec_len_issuer #(
        .TAG_W       (TAG_W),
        .RST_CYC     (RST_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK2 (CLK2),
        .RST  (RST),
        .bus  (bus)
    );

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK2);
        #1;
    endtask

    function automatic logic [95:0] mk_vec(input logic [31:0] l1, input logic [31:0] l2,
                                           input logic [31:0] l3);
        logic [95:0] v;
        v = '0;
        v[LANE_1*LANE_W +: LANE_W] = l1;
        v[LANE_2*LANE_W +: LANE_W] = l2;
        v[LANE_3*LANE_W +: LANE_W] = l3;
        return v;
    endfunction

    // offer a job, see it accepted, and measure how long u_rst_n stays low
    task automatic start_job(input logic [95:0] a, input logic [95:0] b,
                             input logic [TAG_W-1:0] tag, input bit stale);
        int n;
        bus.job_a = a; bus.job_b = b; bus.job_tag = tag; bus.job_valid = 1'b1;
        n = 0;
        while (!bus.job_ready && n < 50) begin step(); n++; end
        step();
        bus.job_valid = 1'b0; bus.job_a = ~a; bus.job_b = ~b; bus.job_tag = ~tag;
        if (!stale) bus.u_out_rdy = 1'b0;
        check_eq("acc_job_ready", 96'(bus.job_ready), 96'(0));
        check_eq("acc_busy", 96'(bus.busy), 96'(1));
        n = 0;
        while (!bus.u_rst_n && n < 20) begin n++; step(); end
        check_eq("kick_len", 96'(n), 96'(RST_CYC));
    endtask

    // full job: the unit model raises u_out_rdy d cycles after u_rst_n rises;
    // with stale set the level is left high, dropped at n=3 and raised again at n=d
    task automatic run_job(input logic [95:0] a, input logic [95:0] b,
                           input logic [TAG_W-1:0] tag, input logic [31:0] res,
                           input int d, input bit respond, input bit stale, input int hold);
        int          n;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_to;
        if (respond && !(TMO_EN && (d + 3 > TIMEOUT_CYC))) begin
            exp_lat = d + 3; exp_data = res; exp_to = 1'b0;
        end else begin
            exp_lat = TIMEOUT_CYC; exp_data = FP_QNAN; exp_to = 1'b1;
        end
        if (stale) bus.u_res = ~res;
        start_job(a, b, tag, stale);
        n = 0;
        while (!bus.res_valid && n < 100) begin
            if (stale && n == 3) bus.u_out_rdy = 1'b0;
            if (respond && n == d) begin bus.u_res = res; bus.u_out_rdy = 1'b1; end
            step();
            n++;
        end
        check_eq("res_latency", 96'(n), 96'(exp_lat));
        check_eq("res_data", 96'(bus.res_data), 96'(exp_data));
        check_eq("res_tag", 96'(bus.res_tag), 96'(tag));
        check_eq("res_timeout", 96'(bus.res_timeout), 96'(exp_to));
        check_eq("u_a_held", bus.u_a, a);
        check_eq("u_b_held", bus.u_b, b);
        check_eq("u_rst_n_wait", 96'(bus.u_rst_n), 96'(1));
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("hold_valid", 96'(bus.res_valid), 96'(1));
            check_eq("hold_data", 96'(bus.res_data), 96'(exp_data));
            check_eq("hold_job_ready", 96'(bus.job_ready), 96'(0));
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check_eq("ret_valid", 96'(bus.res_valid), 96'(0));
        check_eq("ret_job_ready", 96'(bus.job_ready), 96'(1));
        check_eq("ret_busy", 96'(bus.busy), 96'(0));
    endtask

    initial begin
        logic [95:0]      va;
        logic [95:0]      vb;
        logic [TAG_W-1:0] tg;
        int               dly;

        bus.job_valid = 1'b0; bus.job_a = '0; bus.job_b = '0; bus.job_tag = '0;
        bus.u_res = '0; bus.u_out_rdy = 1'b0; bus.res_ready = 1'b0;

        repeat (3) step();
        check_eq("rst_job_ready", 96'(bus.job_ready), 96'(0));
        check_eq("rst_busy", 96'(bus.busy), 96'(0));
        check_eq("rst_u_rst_n", 96'(bus.u_rst_n), 96'(0));
        check_eq("rst_res_valid", 96'(bus.res_valid), 96'(0));
        check_eq("rst_res_data", 96'(bus.res_data), 96'(0));
        check_eq("rst_res_tag", 96'(bus.res_tag), 96'(0));
        check_eq("rst_res_timeout", 96'(bus.res_timeout), 96'(0));
        check_eq("rst_u_a", bus.u_a, 96'(0));
        check_eq("rst_u_b", bus.u_b, 96'(0));

        @(negedge CLK2) RST = 1'b1;
        step();
        check_eq("rel_u_rst_n", 96'(bus.u_rst_n), 96'(1));
        check_eq("rel_job_ready", 96'(bus.job_ready), 96'(1));

        // 3.0/4.0/0 lanes, unit answers 5.0 ten cycles after start, result held 20 cycles
        va = mk_vec(32'h4040_0000, 32'h4080_0000, 32'h0);
        run_job(va, va, 4'd5, 32'h40A0_0000, 10, 1'b1, 1'b0, 20);

        // ready level still high from the previous job must be ignored
        run_job(mk_vec(32'h1, 32'h2, 32'h3), mk_vec(32'h4, 32'h5, 32'h6), 4'd9,
                32'h3F80_0000, 7, 1'b1, 1'b1, 1);

        // completion arrives on the last WAIT cycle of the timeout window
        run_job(mk_vec(32'hA, 32'hB, 32'hC), mk_vec(32'hD, 32'hE, 32'hF), 4'd3,
                32'h4120_0000, TIMEOUT_CYC - 3, 1'b1, 1'b0, 0);

        for (int j = 0; j < 12; j++) begin
            va  = {$urandom, $urandom, $urandom};
            vb  = {$urandom, $urandom, $urandom};
            tg  = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
            dly = int'($urandom_range(0, TMO_EN ? TIMEOUT_CYC : 12));
            run_job(va, vb, tg, $urandom, dly, 1'b1, 1'b0, int'($urandom_range(0, 3)));
        end

        // reset in the middle of WAIT discards the job
        start_job(mk_vec(32'h11, 32'h22, 32'h33), mk_vec(32'h44, 32'h55, 32'h66), 4'd7, 1'b0);
        repeat (3) step();
        #2 RST = 1'b0;
        #1;
        check_eq("midrst_u_rst_n", 96'(bus.u_rst_n), 96'(0));
        check_eq("midrst_res_valid", 96'(bus.res_valid), 96'(0));
        check_eq("midrst_busy", 96'(bus.busy), 96'(0));
        check_eq("midrst_job_ready", 96'(bus.job_ready), 96'(0));
        @(negedge CLK2) RST = 1'b1;
        step();
        check_eq("postrst_job_ready", 96'(bus.job_ready), 96'(1));
        check_eq("postrst_res_valid", 96'(bus.res_valid), 96'(0));
        run_job(mk_vec(32'h7, 32'h8, 32'h9), mk_vec(32'h1, 32'h1, 32'h1), 4'd12,
                32'h4000_0000, 4, 1'b1, 1'b0, 2);

        // the unit never answers
`ifdef VEC_LEN_ISSUER_TIMEOUT_EN
        run_job(mk_vec(32'h5, 32'h6, 32'h7), mk_vec(32'h8, 32'h9, 32'hA), 4'd14,
                32'h0, 0, 1'b0, 1'b0, 1);
`else
        start_job(mk_vec(32'h5, 32'h6, 32'h7), mk_vec(32'h8, 32'h9, 32'hA), 4'd14, 1'b0);
        repeat (60) step();
        check_eq("stuck_busy", 96'(bus.busy), 96'(1));
        check_eq("stuck_res_valid", 96'(bus.res_valid), 96'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
